test_unit_sequencer: RTL and testbench
======================================

Name: test_unit_sequencer

Overview:
- Sequences a chain of NUM simulation test units.
- Launches one unit at a time: raises its go line, then waits for that unit's pass or fail. Records a per-unit verdict, then advances to the next unit or stops.
- Replaces hard-wired pass chaining between units. Adds timeout, fail-stop, abort and a summary verdict for the sim top.

Parameters:
- NUM, 4, number of test units sequenced (>=1).
- TMO_W, 16, width of the per-unit timeout counter.
- STOP_ON_FAIL, 1, 1 = stop the sequence at the first failing unit; 0 = record the failure and continue.

Ports:
- clock  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle start request; honoured only in IDLE or DONE.
- abort  input  1  synchronous abort; returns the block to IDLE.
- tmo_limit  input  TMO_W  cycles allowed per unit; 0 disables the timeout.
- unit_go  output  NUM  level enable to each unit (from_up_pass of that unit).
- unit_pass  input  NUM  level pass from each unit (to_down_pass of that unit).
- unit_fail  input  NUM  level fail from each unit.
- busy  output  1  high while in RUN.
- cur_unit  output  $clog2(NUM) (min 1)  index of the active unit.
- res_valid  output  NUM  verdict recorded for unit i.
- res_pass  output  NUM  verdict of unit i (meaningful when res_valid[i]=1).
- tmo_err  output  NUM  unit i ended by timeout.
- all_done  output  1  high in DONE.
- all_pass  output  1  high in DONE when every bit of res_valid and res_pass is 1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, cur_unit=0, timer=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Clear res_valid, res_pass and tmo_err; set cur_unit=0 and timer=0.
  - Next cycle: state=RUN, unit_go[0]=1. This is 1-cycle latency.
- RUN, per cycle, evaluated for unit i=cur_unit only; inputs of other units are ignored:
  - Fail: unit_fail[i]=1. Fail has priority over pass when both are high. Set res_valid[i]=1 and res_pass[i]=0.
  - Pass: unit_pass[i]=1 and not fail. Set res_valid[i]=1 and res_pass[i]=1.
  - Timeout: neither pass nor fail, tmo_limit!=0, and timer==tmo_limit-1. Set res_valid[i]=1, res_pass[i]=0, tmo_err[i]=1.
  - Otherwise: timer increments, saturating at all-ones.
- Advance, on any verdict:
  - If i==NUM-1, or the verdict was a fail/timeout with STOP_ON_FAIL=1: state=DONE next cycle.
  - Else: cur_unit=i+1, timer=0, and unit_go[i+1]=1 next cycle.
- unit_go is cumulative. A bit, once set, stays 1 until the next start, abort or reset, matching pass-chain semantics. unit_go never has a bit above cur_unit set.
- tmo_limit is sampled every cycle. Changing it mid-unit takes effect immediately.
- DONE:
  - all_done=1, busy=0, and all_pass is valid.
  - Results and unit_go hold.
  - start=1 restarts exactly as from IDLE: clear, then RUN with only unit_go[0]=1 in the next cycle.
- start while in RUN: ignored.
- abort (any state):
  - Next cycle: state=IDLE, unit_go=0, busy=0, all_done=0, cur_unit=0.
  - res_* and tmo_err hold their values for inspection.
  - abort has priority over start and over any verdict in the same cycle.
- NUM=1: cur_unit is 1 bit and always 0. The first verdict goes directly to DONE.
- Reset asserted mid-RUN: immediate return to the reset values. No verdict is recorded.

Test Plan:
- NUM=4, tmo_limit=0. start at cycle 10. Each unit asserts pass 5 cycles after its go.
  - Required: unit_go steps 0001→0011→0111→1111, each step 1 cycle after the prior pass.
  - all_done=1 and all_pass=1 at the cycle after unit 3's pass; res_pass=1111.
- STOP_ON_FAIL=1, unit 1 asserts fail.
  - Required: DONE next cycle, unit_go=0011, res_valid=0011, res_pass=0001, all_pass=0, unit_go[2] never set.
- STOP_ON_FAIL=0, same stimulus.
  - Required: sequence completes, res_valid=1111, res_pass=1101, all_pass=0.
- tmo_limit=8, unit 2 never responds.
  - Required: tmo_err=0100 exactly 8 cycles after unit_go[2] rises, res_pass[2]=0; the STOP_ON_FAIL=0 sequence then proceeds to unit 3.
- Simultaneous events:
  - unit_pass and unit_fail both high on unit 0 → recorded as fail.
  - start during RUN → no effect.
  - abort together with pass on unit 1 → IDLE, res_valid[1] stays 0.
- Reset mid-RUN at unit 2, then start → clean restart with unit_go=0001 and res_*=0.

Source files
------------

// File: rtl/test_unit_sequencer.sv
// Sequences NUM simulation test units one at a time, recording a per-unit verdict,
// with per-unit timeout, optional stop-on-fail, abort, and a summary verdict.
module test_unit_sequencer #(
  parameter int unsigned NUM          = 4,
  parameter int unsigned TMO_W        = 16,
  parameter bit          STOP_ON_FAIL = 1'b1,
  localparam int unsigned CW          = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [TMO_W-1:0] tmo_limit,
  output logic [NUM-1:0]   unit_go,
  input  logic [NUM-1:0]   unit_pass,
  input  logic [NUM-1:0]   unit_fail,
  output logic             busy,
  output logic [CW-1:0]    cur_unit,
  output logic [NUM-1:0]   res_valid,
  output logic [NUM-1:0]   res_pass,
  output logic [NUM-1:0]   tmo_err,
  output logic             all_done,
  output logic             all_pass
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [NUM-1:0]   go_q, go_d;
  logic [CW-1:0]    cur_q, cur_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [NUM-1:0]   vld_q, vld_d;
  logic [NUM-1:0]   pas_q, pas_d;
  logic [NUM-1:0]   tmo_q, tmo_d;

  logic is_fail, is_pass, is_tmo, is_last;

  // Only the active unit's inputs matter; fail wins over pass.
  assign is_fail = unit_fail[cur_q];
  assign is_pass = unit_pass[cur_q] && !is_fail;
  assign is_tmo  = !unit_fail[cur_q] && !unit_pass[cur_q] && (tmo_limit != '0) &&
                   (timer_q == tmo_limit - TMO_W'(1));
  assign is_last = (cur_q == CW'(NUM - 1));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d = state_q;
    go_d    = go_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    vld_d   = vld_q;
    pas_d   = pas_q;
    tmo_d   = tmo_q;

    if (abort) begin
      state_d = S_IDLE;
      go_d    = '0;
      cur_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_RUN;
            go_d    = NUM'(1);
            cur_d   = '0;
            timer_d = '0;
            vld_d   = '0;
            pas_d   = '0;
            tmo_d   = '0;
          end
        end
        S_RUN: begin
          if (is_fail || is_pass || is_tmo) begin
            vld_d[cur_q] = 1'b1;
            pas_d[cur_q] = is_pass;
            tmo_d[cur_q] = is_tmo;
            if (is_last || (!is_pass && STOP_ON_FAIL)) begin
              state_d = S_DONE;
            end else begin
              cur_d   = cur_q + CW'(1);
              timer_d = '0;
              go_d    = go_q | (NUM'(1) << (cur_q + CW'(1)));
            end
          end else if (timer_q != '1) begin
            timer_d = timer_q + TMO_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      go_q    <= '0;
      cur_q   <= '0;
      timer_q <= '0;
      vld_q   <= '0;
      pas_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      cur_q   <= cur_d;
      timer_q <= timer_d;
      vld_q   <= vld_d;
      pas_q   <= pas_d;
      tmo_q   <= tmo_d;
    end
  end

  assign unit_go   = go_q;
  assign cur_unit  = cur_q;
  assign res_valid = vld_q;
  assign res_pass  = pas_q;
  assign tmo_err   = tmo_q;
  assign busy      = (state_q == S_RUN);
  assign all_done  = (state_q == S_DONE);
  assign all_pass  = (state_q == S_DONE) && (&vld_q) && (&pas_q);

endmodule

// File: tb/tb_test_unit_sequencer.sv
// Directed bench: a continue-on-fail and a stop-on-fail sequencer share stimulus;
// expected snapshots are queued when stimulus is driven and compared after the edge.
module tb_test_unit_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       allp;
    logic [1:0] cur;
    logic [3:0] go;
    logic [3:0] vld;
    logic [3:0] pas;
    logic [3:0] tmo;
  } snap_t;

  typedef struct {
    string tag;
    snap_t c;
    snap_t s;
  } sb_t;

  logic        clock, rst_n, start, abort;
  logic [15:0] tmo_limit;
  logic [3:0]  unit_pass, unit_fail;

  logic [3:0] go_c, vld_c, pas_c, tmo_c, go_s, vld_s, pas_s, tmo_s;
  logic [1:0] cur_c, cur_s;
  logic       busy_c, done_c, allp_c, busy_s, done_s, allp_s;

  int    total = 0;
  int    bad   = 0;
  snap_t exp_c, exp_s;
  sb_t   sb_q[$];

  test_unit_sequencer #(.NUM(4), .TMO_W(16), .STOP_ON_FAIL(1'b0)) dut_c (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort), .tmo_limit(tmo_limit),
    .unit_go(go_c), .unit_pass(unit_pass), .unit_fail(unit_fail), .busy(busy_c),
    .cur_unit(cur_c), .res_valid(vld_c), .res_pass(pas_c), .tmo_err(tmo_c),
    .all_done(done_c), .all_pass(allp_c)
  );

  test_unit_sequencer #(.NUM(4), .TMO_W(16), .STOP_ON_FAIL(1'b1)) dut_s (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort), .tmo_limit(tmo_limit),
    .unit_go(go_s), .unit_pass(unit_pass), .unit_fail(unit_fail), .busy(busy_s),
    .cur_unit(cur_s), .res_valid(vld_s), .res_pass(pas_s), .tmo_err(tmo_s),
    .all_done(done_s), .all_pass(allp_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic snap_t obs_c();
    return {busy_c, done_c, allp_c, cur_c, go_c, vld_c, pas_c, tmo_c};
  endfunction

  function automatic snap_t obs_s();
    return {busy_s, done_s, allp_s, cur_s, go_s, vld_s, pas_s, tmo_s};
  endfunction

  // Expected state right after a start is honoured.
  function automatic snap_t started();
    snap_t e = '0;
    e.busy = 1'b1;
    e.go   = 4'b0001;
    return e;
  endfunction

  // Expected state after an abort: results hold, everything else idles.
  function automatic snap_t idled(input snap_t e);
    snap_t r = e;
    r.busy = 1'b0;
    r.done = 1'b0;
    r.allp = 1'b0;
    r.cur  = 2'd0;
    r.go   = 4'b0000;
    return r;
  endfunction

  // Expected state after unit i delivers a verdict.
  function automatic snap_t adv(input snap_t e, input int i, input logic ok, input logic tm,
                                input bit stop);
    snap_t r = e;
    r.vld[i] = 1'b1;
    r.pas[i] = ok;
    r.tmo[i] = tm;
    if (i == 3 || (!ok && stop)) begin
      r.busy = 1'b0;
      r.done = 1'b1;
      r.allp = (&r.vld) && (&r.pas);
    end else begin
      r.go[i+1] = 1'b1;
      r.cur     = 2'(i + 1);
    end
    return r;
  endfunction

  task automatic check(input string tag, input snap_t observed, input snap_t expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Queue the expectation for the current inputs, clock once, then compare both DUTs.
  task automatic cyc(input string tag);
    sb_t ent;
    ent.tag = tag;
    ent.c   = exp_c;
    ent.s   = exp_s;
    sb_q.push_back(ent);
    @(posedge clock);
    #1;
    ent = sb_q.pop_front();
    check({ent.tag, "/cont"}, obs_c(), ent.c);
    check({ent.tag, "/stop"}, obs_s(), ent.s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tmo_limit = '0;
    unit_pass = '0; unit_fail = '0;
    exp_c = '0; exp_s = '0;

    // Reset values
    #2;
    check("reset/cont", obs_c(), exp_c);
    check("reset/stop", obs_s(), exp_s);
    @(posedge clock); #1;
    rst_n = 1'b1;
    repeat (8) cyc("idle");

    // All units pass, 5 cycles after each go
    start = 1'b1;
    exp_c = started(); exp_s = started();
    cyc("start1");
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (4) cyc($sformatf("wait%0d", i));
      unit_pass = 4'(1 << i);
      exp_c = adv(exp_c, i, 1'b1, 1'b0, 1'b0);
      exp_s = adv(exp_s, i, 1'b1, 1'b0, 1'b1);
      cyc($sformatf("pass%0d", i));
      unit_pass = '0;
    end
    repeat (2) cyc("done_hold");

    // Unit 1 fails: stop variant halts, continue variant completes with 1101
    start = 1'b1;
    exp_c = started(); exp_s = started();
    cyc("restart");
    start = 1'b0;
    cyc("f_wait0");
    unit_pass = 4'b0001;
    exp_c = adv(exp_c, 0, 1'b1, 1'b0, 1'b0);
    exp_s = adv(exp_s, 0, 1'b1, 1'b0, 1'b1);
    cyc("f_pass0");
    unit_pass = '0;
    cyc("f_wait1");
    unit_fail = 4'b0010;
    exp_c = adv(exp_c, 1, 1'b0, 1'b0, 1'b0);
    exp_s = adv(exp_s, 1, 1'b0, 1'b0, 1'b1);
    cyc("f_fail1");
    unit_fail = '0;
    repeat (2) cyc("f_wait2");
    unit_pass = 4'b0100;
    exp_c = adv(exp_c, 2, 1'b1, 1'b0, 1'b0);
    cyc("f_pass2");
    unit_pass = 4'b1000;
    exp_c = adv(exp_c, 3, 1'b1, 1'b0, 1'b0);
    cyc("f_pass3");
    unit_pass = '0;

    // Unit 2 silent with tmo_limit=8: timeout exactly 8 cycles after its go
    tmo_limit = 16'd8;
    start = 1'b1;
    exp_c = started(); exp_s = started();
    cyc("t_start");
    start = 1'b0;
    unit_pass = 4'b0001;
    exp_c = adv(exp_c, 0, 1'b1, 1'b0, 1'b0);
    exp_s = adv(exp_s, 0, 1'b1, 1'b0, 1'b1);
    cyc("t_pass0");
    unit_pass = 4'b0010;
    exp_c = adv(exp_c, 1, 1'b1, 1'b0, 1'b0);
    exp_s = adv(exp_s, 1, 1'b1, 1'b0, 1'b1);
    cyc("t_pass1");
    unit_pass = '0;
    repeat (7) cyc("t_wait2");
    exp_c = adv(exp_c, 2, 1'b0, 1'b1, 1'b0);
    exp_s = adv(exp_s, 2, 1'b0, 1'b1, 1'b1);
    cyc("t_tmo2");
    unit_pass = 4'b1000;
    exp_c = adv(exp_c, 3, 1'b1, 1'b0, 1'b0);
    cyc("t_pass3");
    unit_pass = '0;

    // Simultaneous events
    tmo_limit = '0;
    start = 1'b1;
    exp_c = started(); exp_s = started();
    cyc("s_start");
    start = 1'b0;
    unit_pass = 4'b0001;
    unit_fail = 4'b0001;
    exp_c = adv(exp_c, 0, 1'b0, 1'b0, 1'b0);
    exp_s = adv(exp_s, 0, 1'b0, 1'b0, 1'b1);
    cyc("s_pass_and_fail");
    unit_pass = '0;
    unit_fail = '0;
    start = 1'b1;
    exp_s = started();
    cyc("s_start_in_run");
    start = 1'b0;
    unit_pass = 4'b0010;
    abort = 1'b1;
    exp_c = idled(exp_c);
    exp_s = idled(exp_s);
    cyc("s_abort_with_pass");
    unit_pass = '0;
    start = 1'b1;
    cyc("s_abort_with_start");
    start = 1'b0;
    abort = 1'b0;
    cyc("s_idle");

    // Reset asserted mid-run at unit 2, then a clean restart
    start = 1'b1;
    exp_c = started(); exp_s = started();
    cyc("r_start");
    start = 1'b0;
    unit_pass = 4'b0001;
    exp_c = adv(exp_c, 0, 1'b1, 1'b0, 1'b0);
    exp_s = adv(exp_s, 0, 1'b1, 1'b0, 1'b1);
    cyc("r_pass0");
    unit_pass = 4'b0010;
    exp_c = adv(exp_c, 1, 1'b1, 1'b0, 1'b0);
    exp_s = adv(exp_s, 1, 1'b1, 1'b0, 1'b1);
    cyc("r_pass1");
    unit_pass = '0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_c = '0; exp_s = '0;
    check("r_async_reset/cont", obs_c(), exp_c);
    check("r_async_reset/stop", obs_s(), exp_s);
    @(posedge clock); #1;
    rst_n = 1'b1;
    start = 1'b1;
    exp_c = started(); exp_s = started();
    cyc("r_restart");
    start = 1'b0;
    cyc("r_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
